// File: rtl/signed_frame_extrema.sv
// Streaming signed extrema reducer: collapses each frame of FRAME_LEN two's-complement
// samples into its signed max, signed min and unsigned range, with valid/ready on both sides.
module signed_frame_extrema #(
    parameter int WIDTH     = 4,
    parameter int FRAME_LEN = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_range
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] run_max_reg;
    logic [WIDTH-1:0] run_min_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_max_reg;
    logic [WIDTH-1:0] out_min_reg;
    logic [WIDTH-1:0] out_range_reg;

    logic             accept;
    logic             first_sample;
    logic             last_sample;
    logic [WIDTH-1:0] max_next;
    logic [WIDTH-1:0] min_next;
    logic [WIDTH-1:0] range_next;

    // Two signed less-than comparators: [0] is max < sample, [1] is sample < min.
    logic [WIDTH-1:0] cmp_a [2];
    logic [WIDTH-1:0] cmp_b [2];
    logic [1:0]       cmp_lt;

    assign cmp_a[0] = run_max_reg;
    assign cmp_b[0] = in_data;
    assign cmp_a[1] = in_data;
    assign cmp_b[1] = run_min_reg;

    // a - b via ripple carry; less-than is the difference sign XOR the overflow flag,
    // which stays correct when the difference wraps (e.g. 7 vs -8).
    genvar gi, gj;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cmp
            logic [WIDTH:0]   carry;
            logic [WIDTH-1:0] nb;
            logic             diff_msb;
            logic             ovf;

            assign nb       = ~cmp_b[gi];
            assign carry[0] = 1'b1;
            for (gj = 0; gj < WIDTH; gj++) begin : g_bit
                assign carry[gj+1] = (cmp_a[gi][gj] & nb[gj])
                                   | (cmp_a[gi][gj] & carry[gj])
                                   | (nb[gj] & carry[gj]);
            end
            assign diff_msb   = cmp_a[gi][WIDTH-1] ^ nb[WIDTH-1] ^ carry[WIDTH-1];
            assign ovf        = carry[WIDTH] ^ carry[WIDTH-1];
            assign cmp_lt[gi] = diff_msb ^ ovf;
        end
    endgenerate

    assign accept       = in_valid && (state_reg == ACC);
    assign first_sample = (count_reg == '0);
    assign last_sample  = (count_reg == LAST_IDX);

    always_comb begin
        max_next = run_max_reg;
        min_next = run_min_reg;
        if (first_sample) begin
            max_next = in_data;
            min_next = in_data;
        end else begin
            if (cmp_lt[0]) max_next = in_data;
            if (cmp_lt[1]) min_next = in_data;
        end
    end

    // max >= min always, so the true range fits in WIDTH unsigned bits and the
    // modulo-2^WIDTH difference is already exact.
    assign range_next = max_next - min_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ACC;
            count_reg     <= '0;
            run_max_reg   <= '0;
            run_min_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_max_reg   <= '0;
            out_min_reg   <= '0;
            out_range_reg <= '0;
        end else begin
            case (state_reg)
                ACC: begin
                    if (accept) begin
                        run_max_reg <= max_next;
                        run_min_reg <= min_next;
                        if (last_sample) begin
                            count_reg     <= '0;
                            state_reg     <= HOLD;
                            out_valid_reg <= 1'b1;
                            out_max_reg   <= max_next;
                            out_min_reg   <= min_next;
                            out_range_reg <= range_next;
                        end else begin
                            count_reg <= count_reg + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_reg     <= ACC;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= ACC;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == ACC);
    assign out_valid = out_valid_reg;
    assign out_max   = out_max_reg;
    assign out_min   = out_min_reg;
    assign out_range = out_range_reg;

endmodule

// File: tb/tb_signed_frame_extrema.sv
// Directed bench for signed_frame_extrema with WIDTH=4, FRAME_LEN=4; hand-computed
// expectations checked by immediate assertions.
`timescale 1ns/1ps
module tb_signed_frame_extrema;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_max;
    logic [3:0] out_min;
    logic [3:0] out_range;

    int n_cmp = 0;
    int n_bad = 0;

    signed_frame_extrema #(.WIDTH(4), .FRAME_LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_min   (out_min),
        .out_range (out_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] s);
        in_valid = 1'b1;
        in_data  = s;
        @(posedge clk);
        #1;
        $display("accept sample %0d", $signed(s));
        in_valid = 1'b0;
        in_data  = 4'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [3:0] mx,
                                input logic [3:0] mn, input logic [3:0] rg);
        $display("%s: valid=%b max=%h min=%h range=%h", tag, out_valid, out_max, out_min, out_range);
        chk({tag, ".valid"}, {7'd0, out_valid}, 8'd1);
        chk({tag, ".max"},   {4'd0, out_max},   {4'd0, mx});
        chk({tag, ".min"},   {4'd0, out_min},   {4'd0, mn});
        chk({tag, ".range"}, {4'd0, out_range}, {4'd0, rg});
        chk({tag, ".in_ready"}, {7'd0, in_ready}, 8'd0);
    endtask

    task automatic deliver(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        $display("%s deliver: valid=%b in_ready=%b", tag, out_valid, in_ready);
        chk({tag, ".drop"}, {7'd0, out_valid}, 8'd0);
        chk({tag, ".ready_back"}, {7'd0, in_ready}, 8'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b0;
        #12;
        $display("reset: valid=%b max=%h min=%h range=%h", out_valid, out_max, out_min, out_range);
        chk("rst.valid", {7'd0, out_valid}, 8'd0);
        chk("rst.max",   {4'd0, out_max},   8'd0);
        chk("rst.min",   {4'd0, out_min},   8'd0);
        chk("rst.range", {4'd0, out_range}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready", {7'd0, in_ready}, 8'd1);

        // Basic frame
        send(4'd3); send(4'hE); send(4'd5);
        chk("basic.not_yet", {7'd0, out_valid}, 8'd0);
        send(4'd1);
        check_result("basic", 4'h5, 4'hE, 4'h7);
        deliver("basic");
        chk("basic.hold_max", {4'd0, out_max}, 8'h05);

        // Overflowing compares
        send(4'h7); send(4'h8); send(4'h8); send(4'h7);
        check_result("ovf1", 4'h7, 4'h8, 4'hF);
        deliver("ovf1");
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 4'h8; @(posedge clk); #1;
        in_data = 4'h7; @(posedge clk); #1;
        in_data = 4'h0; @(posedge clk); #1;
        in_data = 4'hF; @(posedge clk); #1;
        in_valid = 1'b0;
        $display("ovf2: valid=%b max=%h min=%h range=%h", out_valid, out_max, out_min, out_range);
        chk("ovf2.valid", {7'd0, out_valid}, 8'd1);
        chk("ovf2.max",   {4'd0, out_max},   8'h07);
        chk("ovf2.min",   {4'd0, out_min},   8'h08);
        chk("ovf2.range", {4'd0, out_range}, 8'h0F);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ovf2.one_cycle", {7'd0, out_valid}, 8'd0);

        // Equal samples
        send(4'hF); send(4'hF); send(4'hF); send(4'hF);
        check_result("equal", 4'hF, 4'hF, 4'h0);
        deliver("equal");

        // Backpressure
        send(4'd1); send(4'd2); send(4'd3); send(4'd4);
        check_result("bp", 4'h4, 4'h1, 4'h3);
        in_valid = 1'b1;
        in_data  = 4'd6;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            $display("bp stall %0d: valid=%b in_ready=%b max=%h", i, out_valid, in_ready, out_max);
            chk("bp.stall_valid", {7'd0, out_valid}, 8'd1);
            chk("bp.stall_ready", {7'd0, in_ready},  8'd0);
            chk("bp.stall_max",   {4'd0, out_max},   8'h04);
            chk("bp.stall_range", {4'd0, out_range}, 8'h03);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp.drop", {7'd0, out_valid}, 8'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        send(4'hF); send(4'h0);
        chk("bp.not_yet", {7'd0, out_valid}, 8'd0);
        send(4'h2);
        check_result("bp_next", 4'h6, 4'hF, 4'h7);
        deliver("bp_next");

        // Asynchronous reset mid-frame
        send(4'd7); send(4'd6);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async rst: valid=%b max=%h min=%h range=%h", out_valid, out_max, out_min, out_range);
        chk("arst.valid", {7'd0, out_valid}, 8'd0);
        chk("arst.max",   {4'd0, out_max},   8'd0);
        chk("arst.min",   {4'd0, out_min},   8'd0);
        chk("arst.range", {4'd0, out_range}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        send(4'd0); send(4'd0); send(4'd0);
        chk("arst.not_yet", {7'd0, out_valid}, 8'd0);
        send(4'd4);
        check_result("arst", 4'h4, 4'h0, 4'h4);
        deliver("arst");

        // Bubbles between samples
        send(4'hD); idle(1);
        send(4'h2); idle(3);
        send(4'hB); idle(2);
        chk("bub.not_yet", {7'd0, out_valid}, 8'd0);
        send(4'h2);
        check_result("bubble", 4'h2, 4'hB, 4'h7);
        deliver("bubble");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
